// File: rtl/ar_bus_seq.sv
// ar_bus_seq: 24-bit address register plus a bus sequencer. The sequencer runs
// one memory read or write cycle per request, with optional wait states and a
// bounded wait timeout.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   ibus, aext, load_ar  load AR <= {aext, ibus} while idle
//   incr                 AR[15:0] increment while idle (bank AR[23:16] holds)
//   start_rd, start_wr   request one read or write cycle
//   nwaitst              active-low wait-state request from slow devices
//   wdata, db_out, db_oe write data latched on start, driven during write cycle
//   db_in, rdata         read data sampled from DB and captured
//   ab                   address bus, always equal to AR
//   nmem, nr, nw         active-low registered strobes
//   busy, done, timeout, proto_err  status (done/proto_err are 1-cycle pulses)
module ar_bus_seq #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ibus,
  input  logic [7:0]  aext,
  input  logic        load_ar,
  input  logic        incr,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic        nwaitst,
  input  logic [15:0] wdata,
  input  logic [15:0] db_in,
  output logic [23:0] ab,
  output logic        nmem,
  output logic        nr,
  output logic        nw,
  output logic [15:0] db_out,
  output logic        db_oe,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        proto_err
);

  typedef enum logic [2:0] {IDLE, ADDR, STRB1, STRB2, WAIT, HOLD} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state;
  logic        is_wr;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;
  logic [23:0] ar;

  assign ab       = ar;
  assign wait_nxt = wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      wait_cnt  <= 8'd0;
      ar        <= 24'd0;
      nmem      <= 1'b1;
      nr        <= 1'b1;
      nw        <= 1'b1;
      db_out    <= 16'd0;
      db_oe     <= 1'b0;
      rdata     <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      proto_err <= 1'b0;
      case (state)
        IDLE: begin
          // AR update lands on the same edge as the move to ADDR, so a
          // simultaneous load/incr is visible on ab for the new cycle.
          if (load_ar)
            ar <= {aext, ibus};
          else if (incr)
            ar[15:0] <= ar[15:0] + 16'd1;
          if (start_rd && start_wr) begin
            proto_err <= 1'b1;
          end else if (start_rd || start_wr) begin
            state   <= ADDR;
            is_wr   <= start_wr;
            busy    <= 1'b1;
            nmem    <= 1'b0;
            timeout <= 1'b0;
            db_oe   <= start_wr;
            if (start_wr)
              db_out <= wdata;
          end
        end
        ADDR: begin
          state <= STRB1;
          nr    <= is_wr;
          nw    <= ~is_wr;
        end
        STRB1: state <= STRB2;
        STRB2: begin
          if (nwaitst) begin
            state <= HOLD;
            nr    <= 1'b1;
            nw    <= 1'b1;
            done  <= 1'b1;
            if (!is_wr)
              rdata <= db_in;
          end else begin
            state    <= WAIT;
            wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          // A released wait request wins over the limit on the same cycle.
          if (nwaitst) begin
            state <= HOLD;
            nr    <= 1'b1;
            nw    <= 1'b1;
            done  <= 1'b1;
            if (!is_wr)
              rdata <= db_in;
          end else if (wait_nxt == WAIT_LIMIT) begin
            state   <= HOLD;
            nr      <= 1'b1;
            nw      <= 1'b1;
            done    <= 1'b1;
            timeout <= 1'b1;
            if (!is_wr)
              rdata <= 16'hFFFF;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        HOLD: begin
          state <= IDLE;
          busy  <= 1'b0;
          nmem  <= 1'b1;
          db_oe <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          nmem  <= 1'b1;
          nr    <= 1'b1;
          nw    <= 1'b1;
          db_oe <= 1'b0;
        end
      endcase
      if (state != IDLE && (start_rd || start_wr))
        proto_err <= 1'b1;
    end
  end

endmodule
